alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//   Issue-side controller for the 4-bit combinational ALU (opcodes 00 ADD, 01 SUB, 10 AND, 11 OR).
//   - Accepts 10-bit instructions over a valid/ready handshake and queues them in a FIFO.
//   - Holds a 4x4-bit register file, drives the ALU operands and opcode, and captures the ALU result.
//   - Writes the result back and presents it on a valid/ready result port.
//   - Sits between a command source (testbench or sequencer) and the ALU instance.
// PARAMETERS
//   DATA_W      4  operand/result width; fixed to match the ALU
//   FIFO_DEPTH  4  instruction FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1   single clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   instruction valid
//   in_ready    out  1   FIFO not full
//   in_instr    in   10  instruction word (format below)
//   alu_opcode  out  2   to ALU opcode
//   alu_a       out  4   to ALU A
//   alu_b       out  4   to ALU B
//   alu_result  in   4   from ALU result (combinational, same cycle)
//   res_valid   out  1   result valid
//   res_ready   in   1   result accepted
//   res_data    out  4   captured ALU result
//   res_rd      out  2   destination register of res_data
//   fifo_count  out  3   FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//   Clocking and reset
//   - One clock; reset is asynchronous and active-low.
//   - On reset: in_ready=1, res_valid=0, res_data=0, res_rd=0, alu_*=0, fifo_count=0.
//   - Reset also empties the FIFO, clears every register to 0 and puts the FSM in IDLE.
//   - Reset mid-operation discards all queued and in-flight instructions; no result is emitted.
//   Instruction format
//   - instr[9]=1 is LI: rd=[5:4], imm=[3:0]; bits [8:6] are ignored.
//   - instr[9]=0 is ALU op: [8] ignored, op=[7:6], rd=[5:4], rs1=[3:2], rs2=[1:0].
//   Input handshake
//   - A push occurs on in_valid && in_ready.
//   - in_ready = !full. A pop in the same cycle does NOT free a slot for a push while full.
//   FSM: IDLE, EXEC, RESP
//   - IDLE, FIFO empty: stay in IDLE.
//   - IDLE, head is LI: write reg[rd]=imm, pop, stay in IDLE. One LI per cycle; no result output.
//   - IDLE, head is ALU op: go to EXEC; no pop.
//   - EXEC: drive alu_opcode=op, alu_a=reg[rs1], alu_b=reg[rs2].
//     At the clock edge: res_data<=alu_result, res_rd<=rd, reg[rd]<=alu_result, pop, go to RESP.
//   - RESP: res_valid=1; res_data and res_rd are held stable until res_ready.
//     On res_ready, go to IDLE; res_valid drops the next cycle.
//   - Outside EXEC, alu_opcode/alu_a/alu_b are driven to 0.
//   Arithmetic and hazards
//   - Results are modulo 16 (ALU wrap-around). No carry or borrow flag.
//   - rs1, rs2 and rd may alias; reads in EXEC see all earlier writes.
//     Instructions execute strictly in order, so there is no hazard.
//   Timing
//   - Latency: ALU op pushed at edge E0 into an empty FIFO with the FSM in IDLE.
//     EXEC during cycle E1..E2; res_valid=1 after E2.
//   - Throughput: at most one ALU op every 3 cycles with res_ready held at 1.
//   - fifo_count updates on every push and pop; push and pop in the same cycle leave it unchanged.
// STRUCTURE
//   Package alu_issue_pkg holds:
//   - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
//   - Instruction field bit positions and the LI flag bit.
//   - FSM state encoding.
//   Sub-module alu_cmd_fifo:
//   - Synchronous FIFO, parameter DEPTH, width 10.
//   - Ports push/pop/full/empty/count/head.
//   - Asynchronous active-low reset; head is combinational (show-ahead).
//   The register file and FSM live in the top level; the ALU is NOT instantiated inside.
// TESTING
//   Bench wires the ALU to the alu_* ports.
//   1 LI r0=5, LI r1=3, ADD r2=r0+r1 -> res_data=8, res_rd=2; res_valid rises 2 cycles after the ADD push.
//   2 LI r0=3, LI r1=5, SUB r3=r0-r1 -> res_data=14 (wrap); ADD r3=r3+r3 -> res_data=12 (wrap).
//   3 LI r0=12, LI r1=6: AND r2 -> 4; OR r2=r0|3 (LI r1=3 first) -> 15; ops with rs1=rs2=rd alias correctly.
//   4 Hold res_ready=0 for 10 cycles and push 6 ALU ops.
//     -> res_data is stable, fifo_count reaches 4 and in_ready=0, extra pushes are dropped.
//     -> Results then drain in order.
//   5 Assert rst_n=0 during RESP with 3 entries queued.
//     -> res_valid=0 immediately, fifo_count=0, all regs 0; a following ADD r0+r1 gives 0.
//   6 Back-to-back LI pushes every cycle: one LI retires per cycle, fifo_count never exceeds 1.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller.
//   - Opcode constants for the 4-bit combinational ALU.
//   - Instruction field positions and the LI flag bit.
//   - FSM state encoding.
//   - Small field-extraction helpers used by the controller.
package alu_issue_pkg;

  localparam int INSTR_W = 10;
  localparam int RF_AW   = 2;
  localparam int RF_N    = 1 << RF_AW;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int LI_BIT = 9;
  localparam int OP_LO  = 6;
  localparam int RD_LO  = 4;
  localparam int RS1_LO = 2;
  localparam int RS2_LO = 0;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_li(input logic [INSTR_W-1:0] instr);
    return instr[LI_BIT];
  endfunction

  function automatic logic [1:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LO +: 2];
  endfunction

  function automatic logic [RF_AW-1:0] get_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LO +: RF_AW];
  endfunction

  function automatic logic [RF_AW-1:0] get_rs1(input logic [INSTR_W-1:0] instr);
    return instr[RS1_LO +: RF_AW];
  endfunction

  function automatic logic [RF_AW-1:0] get_rs2(input logic [INSTR_W-1:0] instr);
    return instr[RS2_LO +: RF_AW];
  endfunction

  function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_LO +: IMM_W];
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead instruction FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   head       : current oldest entry, valid whenever !empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for a 4-bit combinational ALU.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : instruction handshake (in_ready = FIFO not full)
//   in_instr               : 10-bit instruction (LI or ALU op)
//   alu_opcode/alu_a/alu_b : operands to the external ALU, non-zero only in EXEC
//   alu_result             : combinational ALU result
//   res_valid/res_ready    : result handshake
//   res_data/res_rd        : captured result and its destination register
//   fifo_count             : instruction FIFO occupancy
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            in_instr,
  output logic [1:0]                    alu_opcode,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  input  logic [DATA_W-1:0]             alu_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_W-1:0]             res_data,
  output logic [RF_AW-1:0]              res_rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  state_t               state;
  logic [DATA_W-1:0]    rf [RF_N];
  logic [INSTR_W-1:0]   head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 head_is_li;
  logic                 unused_head_bits;

  assign in_ready   = !fifo_full;
  assign head_is_li = is_li(head);
  // Bit 8 is a don't-care in both instruction forms.
  assign unused_head_bits = head[8];

  // LIs retire straight from IDLE; an ALU op stays at the head until its
  // result is captured at the end of EXEC.
  assign fifo_pop = ((state == ST_IDLE) && !fifo_empty && head_is_li) ||
                    (state == ST_EXEC);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   (in_instr),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      for (int i = 0; i < RF_N; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_is_li) begin
              rf[get_rd(head)] <= DATA_W'(get_imm(head));
            end else begin
              // Operands are registered on entry to EXEC; every earlier
              // LI/ALU write has already landed in rf by this edge.
              state      <= ST_EXEC;
              alu_opcode <= get_op(head);
              alu_a      <= rf[get_rs1(head)];
              alu_b      <= rf[get_rs2(head)];
            end
          end
        end
        ST_EXEC: begin
          res_data         <= alu_result;
          res_rd           <= get_rd(head);
          rf[get_rd(head)] <= alu_result;
          res_valid        <= 1'b1;
          alu_opcode       <= '0;
          alu_a            <= '0;
          alu_b            <= '0;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
